// File: rtl/decode_issue_ctrl.sv
// Decode issue controller: one-entry hold register, 16-entry register scoreboard,
// in-flight write limit. Optional writeback bypass: DECODE_ISSUE_WB_BYPASS_EN.
module decode_issue_ctrl #(
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [63:0] fetch_inst,
  output logic [63:0] dec_inst,
  input  logic [3:0]  dec_raddr1,
  input  logic [3:0]  dec_raddr2,
  input  logic [3:0]  dec_waddr,
  input  logic        dec_wen,
  input  logic        dec_imm_sel,
  output logic        issue_valid,
  input  logic        issue_ready,
  input  logic        wb_valid,
  input  logic [3:0]  wb_addr,
  input  logic        flush,
  output logic [15:0] busy,
  output logic [3:0]  inflight_cnt,
  output logic [31:0] stall_cnt,
  output logic        wb_err
);
  localparam int unsigned NREG = 16;
  localparam int unsigned CW   = 4;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [NREG-1:0] wb_onehot, set_onehot, clr_onehot, busy_chk;
  logic [CW-1:0]   cnt_chk;
  logic            haz, issue_fire, accept, wb_hit;

  assign wb_onehot = wb_valid ? (NREG'(1) << wb_addr) : '0;
  assign wb_hit    = |(wb_onehot & busy);

  // Register view used for the hazard check; bypass lets a retiring write unblock now
`ifdef DECODE_ISSUE_WB_BYPASS_EN
  assign busy_chk = busy & ~wb_onehot;
  assign cnt_chk  = inflight_cnt - CW'(wb_hit);
`else
  assign busy_chk = busy;
  assign cnt_chk  = inflight_cnt;
`endif

  // busy[0] is never set, so register 0 cannot raise a field hazard
  assign haz = busy_chk[dec_raddr1]
             | (~dec_imm_sel & busy_chk[dec_raddr2])
             | (dec_wen & busy_chk[dec_waddr])
             | (dec_wen & (cnt_chk == CW'(MAX_INFLIGHT)));

  // Hold-register FSM
  always_ff @(posedge clk) begin
    if (!rst) state <= EMPTY;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    issue_valid = 1'b0;
    fetch_ready = 1'b0;
    issue_valid = (state == FULL) & ~haz & ~flush;
    fetch_ready = ~flush & ((state == EMPTY) | (issue_valid & issue_ready));
    if (flush)                            state_nxt = EMPTY;
    else if (fetch_valid & fetch_ready)   state_nxt = FULL;
    else if (issue_valid & issue_ready)   state_nxt = EMPTY;
  end

  assign issue_fire = issue_valid & issue_ready;
  assign accept     = fetch_valid & fetch_ready;

  // New writer's set is applied after the retiring clear, so set wins on a collision
  assign set_onehot = (issue_fire & dec_wen & (dec_waddr != 4'd0)) ? (NREG'(1) << dec_waddr) : '0;
  assign clr_onehot = wb_onehot & busy;

  always_ff @(posedge clk) begin
    if (!rst) begin
      dec_inst     <= '0;
      busy         <= '0;
      inflight_cnt <= '0;
      stall_cnt    <= '0;
      wb_err       <= 1'b0;
    end else begin
      if (accept) dec_inst <= fetch_inst;
      busy         <= (busy & ~clr_onehot) | set_onehot;
      inflight_cnt <= inflight_cnt + CW'(|set_onehot) - CW'(|clr_onehot);
      if (wb_valid & (wb_addr != 4'd0) & ~busy[wb_addr]) wb_err <= 1'b1;
      if ((state == FULL) & ~flush & ~issue_valid & (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Randomized bench for decode_issue_ctrl against a set-based scoreboard model.
// The bench plays the decode stage: fields are sliced from dec_inst.
module tb_decode_issue_ctrl;
  localparam int unsigned MAXI = 4;

  logic        clk = 1'b0;
  logic        rst, fetch_valid, fetch_ready, dec_wen, dec_imm_sel;
  logic        issue_valid, issue_ready, wb_valid, flush, wb_err;
  logic [63:0] fetch_inst, dec_inst;
  logic [3:0]  dec_raddr1, dec_raddr2, dec_waddr, wb_addr, inflight_cnt;
  logic [15:0] busy;
  logic [31:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  // Reference state: which registers have an outstanding write, plus hold/counters
  bit          pend [16];
  bit          m_full, m_err;
  logic [63:0] m_inst;
  longint      m_stall;

  always #5 clk = ~clk;

  assign dec_raddr1  = dec_inst[3:0];
  assign dec_raddr2  = dec_inst[7:4];
  assign dec_waddr   = dec_inst[11:8];
  assign dec_wen     = dec_inst[12];
  assign dec_imm_sel = dec_inst[13];

  decode_issue_ctrl #(.MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_inst(fetch_inst), .dec_inst(dec_inst), .dec_raddr1(dec_raddr1),
    .dec_raddr2(dec_raddr2), .dec_waddr(dec_waddr), .dec_wen(dec_wen),
    .dec_imm_sel(dec_imm_sel), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush), .busy(busy),
    .inflight_cnt(inflight_cnt), .stall_cnt(stall_cnt), .wb_err(wb_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit blocked(input int r);
    bit b = pend[r];
`ifdef DECODE_ISSUE_WB_BYPASS_EN
    if (wb_valid && int'(wb_addr) == r) b = 1'b0;
`endif
    return b;
  endfunction

  function automatic int n_pending();
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(pend[i]);
    return n;
  endfunction

  function automatic int n_for_limit();
    int n = n_pending();
`ifdef DECODE_ISSUE_WB_BYPASS_EN
    if (wb_valid && pend[wb_addr]) n--;
`endif
    return n;
  endfunction

  task automatic model_reset();
    foreach (pend[i]) pend[i] = 1'b0;
    m_full = 1'b0; m_err = 1'b0; m_inst = '0; m_stall = 0;
  endtask

  // One clock: check all outputs mid-cycle, then advance the model at the edge
  task automatic step();
    int ra1, ra2, wa;
    bit wen, imm, haz, iv, fr, fire, acc;
    logic [15:0] bexp;
    #1;
    ra1 = int'(m_inst[3:0]);  ra2 = int'(m_inst[7:4]);  wa = int'(m_inst[11:8]);
    wen = m_inst[12];         imm = m_inst[13];
    haz = blocked(ra1) || (!imm && blocked(ra2)) || (wen && blocked(wa))
          || (wen && n_for_limit() == int'(MAXI));
    iv  = m_full && !haz && !flush;
    fr  = !flush && (!m_full || (iv && issue_ready));
    for (int i = 0; i < 16; i++) bexp[i] = pend[i];
    chk("fetch_ready",  64'(fetch_ready),  64'(fr));
    chk("issue_valid",  64'(issue_valid),  64'(iv));
    chk("dec_inst",     dec_inst,          m_inst);
    chk("busy",         64'(busy),         64'(bexp));
    chk("inflight_cnt", 64'(inflight_cnt), 64'(n_pending()));
    chk("stall_cnt",    64'(stall_cnt),    64'(m_stall));
    chk("wb_err",       64'(wb_err),       64'(m_err));
    @(posedge clk);
    fire = iv && issue_ready;
    acc  = fetch_valid && fr;
    if (!rst) model_reset();
    else begin
      if (wb_valid) begin
        if (wb_addr != 4'd0 && !pend[wb_addr]) m_err = 1'b1;
        else pend[wb_addr] = 1'b0;
      end
      if (fire && wen && wa != 0) pend[wa] = 1'b1;
      if (m_full && !flush && !iv && m_stall != 64'hFFFF_FFFF) m_stall++;
      if (acc) m_inst = fetch_inst;
      if (flush)     m_full = 1'b0;
      else if (acc)  m_full = 1'b1;
      else if (fire) m_full = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic cyc(input bit fv, input logic [63:0] inst, input bit ir,
                     input bit wv, input logic [3:0] wa, input bit fl);
    fetch_valid = fv; fetch_inst = inst; issue_ready = ir;
    wb_valid = wv; wb_addr = wa; flush = fl;
    step();
  endtask

  initial begin
    int pl [$];
    logic [63:0] ri;
    rst = 1'b0; fetch_valid = 1'b0; fetch_inst = '0; issue_ready = 1'b0;
    wb_valid = 1'b0; wb_addr = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b1;

    // Back-to-back independent writers
    cyc(1, 64'h1201, 1, 0, 0, 0);
    cyc(1, 64'h1403, 1, 0, 0, 0);
    cyc(0, 64'h0,    1, 0, 0, 0);
    chk("b2b_busy", 64'(busy), 64'h0014);
    chk("b2b_cnt",  64'(inflight_cnt), 64'd2);
    cyc(0, 64'h0, 1, 1, 4'd2, 0);
    cyc(0, 64'h0, 1, 1, 4'd4, 0);

    // RAW stall on x5, then flush while stalled
    cyc(1, 64'h1500, 1, 0, 0, 0);
    cyc(1, 64'h0005, 1, 0, 0, 0);
    cyc(0, 64'h0,    1, 0, 0, 0);
    cyc(0, 64'h0,    1, 0, 0, 0);
    fetch_valid = 1'b1; flush = 1'b1; #1;
    chk("flush_iv", 64'(issue_valid), 64'd0);
    chk("flush_fr", 64'(fetch_ready), 64'd0);
    step();
    chk("flush_busy", 64'(busy), 64'h0020);
    cyc(0, 64'h0, 1, 1, 4'd5, 0);

    // Writeback to an idle register is flagged
    cyc(0, 64'h0, 1, 1, 4'd7, 0);
    chk("wb_err_set", 64'(wb_err), 64'd1);

    // Random traffic with writebacks drawn from the model's pending set
    for (int n = 0; n < 3000; n++) begin
      ri = {$urandom, $urandom};
      ri[3:0]   = 4'($urandom_range(0, 7));
      ri[7:4]   = 4'($urandom_range(0, 7));
      ri[11:8]  = 4'($urandom_range(0, 7));
      ri[12]    = ($urandom_range(0, 3) != 0);
      ri[13]    = ($urandom_range(0, 2) == 0);
      pl.delete();
      for (int i = 1; i < 16; i++) if (pend[i]) pl.push_back(i);
      fetch_valid = ($urandom_range(0, 9) < 7);
      fetch_inst  = ri;
      issue_ready = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 19) == 0);
      rst         = ($urandom_range(0, 499) != 0);
      wb_valid    = 1'b0; wb_addr = '0;
      if (pl.size() > 0 && $urandom_range(0, 9) < 4) begin
        wb_valid = 1'b1;
        wb_addr  = 4'(pl[$urandom_range(0, pl.size() - 1)]);
      end else if ($urandom_range(0, 49) == 0) begin
        wb_valid = 1'b1;
        wb_addr  = 4'($urandom_range(0, 15));
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/decode_issue_ctrl.md
# decode_issue_ctrl

Issue controller wrapped around the decode stage. It holds one fetched instruction for decode, checks decode's register fields against a 16-entry scoreboard, and releases the instruction downstream only when it is hazard-free. Busy bits are set on issue and cleared by writeback. The block sits between fetch and execute and is the only block that sequences decode.

## Interface
- MAX_INFLIGHT, 4: maximum issued-but-not-written-back register writes (1..15).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- fetch_valid  in  1  fetch offers an instruction.
- fetch_ready  out  1  controller accepts it this cycle.
- fetch_inst  in  64  instruction word from fetch.
- dec_inst  out  64  held instruction, driven to decode `inst_i`.
- dec_raddr1, dec_raddr2  in  4 each  source fields returned by decode.
- dec_waddr  in  4  destination field from decode.
- dec_wen  in  1  instruction writes `dec_waddr`.
- dec_imm_sel  in  1  when 1, rs2 is unused and not hazard-checked.
- issue_valid  out  1  held instruction may issue.
- issue_ready  in  1  execute accepts.
- wb_valid  in  1  writeback completes.
- wb_addr  in  4  register written back.
- flush  in  1  discard the held instruction.
- busy  out  16  scoreboard, bit i = register i pending.
- inflight_cnt  out  4  outstanding writes.
- stall_cnt  out  32  saturating count of FULL cycles with `issue_valid=0`.
- wb_err  out  1  sticky; set when writeback targets a register that is not busy.

## Operation
- **States**
  - EMPTY: no held instruction.
  - FULL: instruction in the hold register.
- **fetch_ready**: `= ~flush & (state==EMPTY | issue_fire)`, where `issue_fire = issue_valid & issue_ready`.
- **Fetch accept**: on `fetch_valid & fetch_ready`, load `fetch_inst` into hold and go to (or stay in) FULL.
- **Issue without refill**: `issue_fire` with no accept goes to EMPTY.
- **Flush** has priority.
  - Clear state to EMPTY and force `issue_valid=0` that cycle.
  - The scoreboard and counters are untouched; in-flight writes still retire.
- **Hazard**: `haz` is true if any of the following holds:
  - `busy[raddr1]`
  - `~imm_sel & busy[raddr2]`
  - `wen & busy[waddr]` (WAW)
  - `wen & inflight_cnt==MAX_INFLIGHT`
- **Register 0** never hazards and is never marked busy.
- **issue_valid**: `= FULL & ~haz & ~flush`.
- **Scoreboard update**
  - On `issue_fire & dec_wen & waddr!=0`, set `busy[waddr]`.
  - On `wb_valid` with `busy[wb_addr]`, clear it.
  - Set and clear on the same register in the same cycle: set wins (new writer). The counter is then net unchanged.
- **inflight_cnt**: +1 on a busy-set, -1 on an effective clear; both in the same cycle means unchanged.
- **wb_err**: set when `wb_valid & wb_addr!=0 & ~busy[wb_addr]`. No state is changed by that writeback; the flag clears only on reset.
- **stall_cnt**: increments when FULL & ~flush & ~issue_valid, and saturates at 0xFFFF_FFFF.

## Timing
- Reset values (`rst=0` at an edge):
  - state EMPTY, `dec_inst=0`, `busy=0`.
  - `inflight_cnt=0`, `stall_cnt=0`, `wb_err=0`.
  - `issue_valid=0`.
  - `fetch_ready=1` once `rst=1`.
- Reset mid-operation discards the held instruction and all busy bits.
- Latency: an instruction accepted at edge N is on `dec_inst` after edge N. `issue_valid` can be high in cycle N+1; issue is combinational through decode.
- Throughput: 1 instruction per cycle via the issue+accept overlap.
- `issue_valid`, once high, may drop only on `flush` or a new hazard from an `inflight_cnt` change. Downstream must not rely on stability beyond the current cycle.
- Busy set on issue at edge N is visible to the next instruction's check in cycle N+1.

## Configuration
- `DECODE_ISSUE_WB_BYPASS_EN` defined:
  - The hazard check uses `busy & ~wb_onehot`, where `wb_onehot` is the decode of `wb_addr` gated by `wb_valid`.
  - The inflight limit uses the count after the same-cycle decrement.
  - A waiting instruction issues in the same cycle as its producer's writeback.
- Undefined: the check uses registered `busy`. Issue occurs one cycle after writeback.

## Test plan
- Reset, then back-to-back independent ALU ops (`raddr1=1`, `waddr=2`, then `raddr1=3`, `waddr=4`) with `issue_ready=1` -> one issue per cycle; busy=0x0014; inflight_cnt=2.
- RAW: issue `wen`, `waddr=5`, then next instruction `raddr1=5` -> stalls, stall_cnt increments each cycle. `wb_valid`, `wb_addr=5` -> issue same cycle with bypass, next cycle without.
- `dec_imm_sel=1` with `raddr2` busy -> no stall. Write to x0 -> busy stays 0, inflight_cnt unchanged.
- MAX_INFLIGHT=4: four writes to regs 1-4 outstanding, fifth write to reg 6 -> stalls until any writeback. Fifth instruction with `wen=0` issues immediately.
- Flush asserted while FULL and stalled -> `issue_valid=0`, `fetch_ready=0` that cycle, EMPTY next cycle, busy unchanged.
- Writeback to a non-busy reg 7 -> wb_err=1 and sticky. Same-cycle issue to reg 3 plus writeback of reg 3 -> busy[3]=1, count unchanged.
